exec_core: RTL and testbench

EXEC_CORE -- requirements
Module: exec_core

---
 rtl/exec_core_pkg.sv | 29 ++
 rtl/exec_core_if.sv | 23 ++
 rtl/exec_seq.sv | 42 ++++
 rtl/exec_core.sv | 121 ++++++++++++
 tb/tb_exec_core.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_core_pkg.sv
// Shared definitions for the exec_core sequencer and datapath.
package exec_core_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StLoad1,
        StLoad2,
        StExec,
        StWrite,
        StNext,
        StHalt
    } state_e;

    // Halt opcode is all-ones; sliced down to the opcode width at the use site.
    localparam logic [63:0] HaltOpcodeAll = '1;

    // Field positions inside a line word {instr_addr, addr_wr, addr1, addr2}, in BUS_WIDTH units.
    localparam int unsigned LineInstr = 3;
    localparam int unsigned LineWr    = 2;
    localparam int unsigned LineAddr1 = 1;
    localparam int unsigned LineAddr2 = 0;

    function automatic logic ram_wait_state(state_e s);
        return (s == StLoad1) || (s == StLoad2) || (s == StWrite);
    endfunction

endpackage

// File: rtl/exec_core_if.sv
// RAM port bundle between exec_core (master) and the data RAM (slave).
interface exec_core_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BUS_WIDTH  = 8
);
    logic                  ram_busy;
    logic [DATA_WIDTH-1:0] data_rd;
    logic                  ram_rd_en;
    logic                  ram_wr_en;
    logic [BUS_WIDTH-1:0]  addr_rd;
    logic [BUS_WIDTH-1:0]  addr_wr;
    logic [DATA_WIDTH-1:0] data_wr;

    modport master (
        input  ram_busy, data_rd,
        output ram_rd_en, ram_wr_en, addr_rd, addr_wr, data_wr
    );

    modport slave (
        output ram_busy, data_rd,
        input  ram_rd_en, ram_wr_en, addr_rd, addr_wr, data_wr
    );
endinterface

// File: rtl/exec_seq.sv
// Instruction sequencer FSM for exec_core.
// EXEC_CORE_RAM_WAIT_EN: when defined, RAM-facing states hold while ram_busy is high.
module exec_seq
    import exec_core_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   start,
    input  logic   halt_op,
    input  logic   ram_busy,
    output state_e state
);

    logic stall;

`ifdef EXEC_CORE_RAM_WAIT_EN
    assign stall = ram_busy && ram_wait_state(state);
`else
    logic unused_ram_busy;
    assign unused_ram_busy = ram_busy;
    assign stall = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= StIdle;
        end else if (!stall) begin
            case (state)
                StIdle, StHalt: if (start) state <= StFetch;
                StFetch:        state <= StDecode;
                StDecode:       state <= StLoad1;
                StLoad1:        state <= StLoad2;
                StLoad2:        state <= halt_op ? StHalt : StExec;
                StExec:         state <= StWrite;
                StWrite:        state <= StNext;
                StNext:         state <= StFetch;
                default:        state <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/exec_core.sv
// Multi-cycle execution core: fetch line, load two operands, run ALU, write back, advance ip.
// EXEC_CORE_RAM_WAIT_EN: when defined, LOAD1/LOAD2/WRITE stall on ram_busy.
module exec_core
    import exec_core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned BUS_WIDTH    = 8,
    parameter int unsigned IP_WIDTH     = 8,
    parameter int unsigned OPCODE_WIDTH = 8,
    parameter int unsigned CTRL_BIT     = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    halted,
    input  logic [4*BUS_WIDTH-1:0]  line,
    output logic [IP_WIDTH-1:0]     ip,
    output logic                    line_mem_en,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output logic [BUS_WIDTH-1:0]    instr_addr,
    output logic                    instr_mem_en,
    exec_core_if.master             ram,
    output logic [OPCODE_WIDTH-1:0] opcode_alu,
    output logic [DATA_WIDTH-1:0]   value1,
    output logic [DATA_WIDTH-1:0]   value2,
    output logic                    alu_en,
    input  logic [DATA_WIDTH-1:0]   result,
    input  logic                    update_ip,
    output logic                    ip_update_en,
    output logic [15:0]             retired
);

    state_e                 state;
    logic [4*BUS_WIDTH-1:0] line_q;
    logic [BUS_WIDTH-1:0]   addr_rd_q, addr_rd_d;
    logic [BUS_WIDTH-1:0]   wr_field;
    logic [DATA_WIDTH-1:0]  result_q;
    logic                   br_q;
    logic                   halt_op;
    logic                   stall;
    logic                   ctrl;

    assign halt_op  = (opcode_alu == HaltOpcodeAll[OPCODE_WIDTH-1:0]);
    assign ctrl     = opcode_alu[CTRL_BIT];
    assign wr_field = line_q[LineWr*BUS_WIDTH +: BUS_WIDTH];

`ifdef EXEC_CORE_RAM_WAIT_EN
    assign stall = ram.ram_busy && ram_wait_state(state);
`else
    assign stall = 1'b0;
`endif

    exec_seq u_seq (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .halt_op  (halt_op),
        .ram_busy (ram.ram_busy),
        .state    (state)
    );

    // In DECODE the line word is still on the input; later states use the registered copy.
    always_comb begin
        addr_rd_d  = addr_rd_q;
        instr_addr = line_q[LineInstr*BUS_WIDTH +: BUS_WIDTH];
        if (state == StDecode) begin
            addr_rd_d  = line[LineAddr1*BUS_WIDTH +: BUS_WIDTH];
            instr_addr = line[LineInstr*BUS_WIDTH +: BUS_WIDTH];
        end else if (state == StLoad1) begin
            addr_rd_d = line_q[LineAddr2*BUS_WIDTH +: BUS_WIDTH];
        end
    end

    assign halted        = (state == StHalt);
    assign line_mem_en   = (state == StFetch);
    assign instr_mem_en  = (state == StDecode);
    assign alu_en        = (state == StExec);
    assign ram.ram_rd_en = (state == StDecode) || (state == StLoad1);
    assign ram.ram_wr_en = (state == StWrite) && !ctrl;
    assign ip_update_en  = (state == StWrite) && ctrl;
    assign ram.addr_rd   = addr_rd_d;
    assign ram.addr_wr   = wr_field;
    assign ram.data_wr   = result_q;

    logic unused_line_q_addr1;
    assign unused_line_q_addr1 = ^line_q[LineAddr1*BUS_WIDTH +: BUS_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            ip         <= '0;
            value1     <= '0;
            value2     <= '0;
            opcode_alu <= '0;
            addr_rd_q  <= '0;
            line_q     <= '0;
            result_q   <= '0;
            br_q       <= 1'b0;
            retired    <= '0;
        end else begin
            addr_rd_q <= addr_rd_d;
            case (state)
                StDecode: line_q <= line;
                StLoad1: if (!stall) begin
                    opcode_alu <= opcode;
                    value1     <= ram.data_rd;
                end
                StLoad2: if (!stall) value2 <= ram.data_rd;
                StExec: begin
                    result_q <= result;
                    br_q     <= update_ip;
                end
                StNext: begin
                    ip      <= (br_q && ctrl) ? IP_WIDTH'(wr_field) : ip + IP_WIDTH'(1);
                    retired <= retired + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_core.sv
// Directed bench for exec_core: instruction table plus halt, stall and reset sequences.
module tb_exec_core;

    localparam int unsigned DW = 8;
    localparam int unsigned BW = 8;
    localparam int unsigned IW = 8;
    localparam int unsigned OW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          halted;
    logic [4*BW-1:0] line = '0;
    logic [IW-1:0] ip;
    logic          line_mem_en;
    logic [OW-1:0] opcode = '0;
    logic [BW-1:0] instr_addr;
    logic          instr_mem_en;
    logic [OW-1:0] opcode_alu;
    logic [DW-1:0] value1, value2;
    logic          alu_en;
    logic [DW-1:0] result;
    logic          update_ip;
    logic          ip_update_en;
    logic [15:0]   retired;
    logic          br;

    exec_core_if #(.DATA_WIDTH(DW), .BUS_WIDTH(BW)) ram_if ();

    exec_core dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .halted       (halted),
        .line         (line),
        .ip           (ip),
        .line_mem_en  (line_mem_en),
        .opcode       (opcode),
        .instr_addr   (instr_addr),
        .instr_mem_en (instr_mem_en),
        .ram          (ram_if),
        .opcode_alu   (opcode_alu),
        .value1       (value1),
        .value2       (value2),
        .alu_en       (alu_en),
        .result       (result),
        .update_ip    (update_ip),
        .ip_update_en (ip_update_en),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    logic [4*BW-1:0] line_mem [256];
    logic [OW-1:0]   imem     [256];
    logic [DW-1:0]   ram_mem  [256];
    logic            ram_accept;

`ifdef EXEC_CORE_RAM_WAIT_EN
    assign ram_accept = !ram_if.ram_busy;
`else
    assign ram_accept = 1'b1;
`endif

    // Synchronous-read memories around the core.
    always @(posedge clk) begin
        if (line_mem_en) line <= line_mem[ip];
        if (instr_mem_en) opcode <= imem[instr_addr];
        if (ram_if.ram_rd_en && ram_accept) ram_if.data_rd <= ram_mem[ram_if.addr_rd];
        if (ram_if.ram_wr_en && ram_accept) ram_mem[ram_if.addr_wr] <= ram_if.data_wr;
    end

    always_comb begin
        case (opcode_alu)
            8'h01:   result = value1 + value2;
            8'h02:   result = value1 - value2;
            8'h03:   result = value1 ^ value2;
            default: result = '0;
        endcase
    end
    assign update_ip = br;

    typedef struct {
        logic [7:0]  ip;
        logic [31:0] line;
        logic        br;
        logic        wr;
        logic [7:0]  wa;
        logic [7:0]  wd;
        logic        ipu;
        logic [7:0]  nip;
        logic [7:0]  v1;
    } vec_t;

    vec_t vecs [8];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Entered at the negedge of a FETCH cycle; returns at the next FETCH (or halt / budget).
    task automatic run_one(input string tag, input vec_t v, input int busy_len,
                           input int exp_lat, input logic [15:0] exp_ret);
        int   cyc;
        logic wr_seen, ipu_seen;
        logic [7:0] wa, wd, v1_act;
        cyc = 0; wr_seen = 1'b0; ipu_seen = 1'b0; wa = '0; wd = '0; v1_act = '0;
        check({tag, "_fetch_ip"}, 32'(ip), 32'(v.ip));
        line_mem[ip] = v.line;
        br = v.br;
        do begin
            @(negedge clk);
            cyc++;
            if (ram_if.ram_wr_en) begin
                wr_seen = 1'b1; wa = ram_if.addr_wr; wd = ram_if.data_wr;
            end
            if (ip_update_en) ipu_seen = 1'b1;
            if (cyc == 3 + busy_len) v1_act = value1;
            if (busy_len > 0 && cyc == 2) ram_if.ram_busy = 1'b1;
            if (busy_len > 0 && cyc == 2 + busy_len) ram_if.ram_busy = 1'b0;
        end while (!line_mem_en && !halted && cyc < 30);
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_wr_en"}, 32'(wr_seen), 32'(v.wr));
        if (v.wr) begin
            check({tag, "_addr_wr"}, 32'(wa), 32'(v.wa));
            check({tag, "_data_wr"}, 32'(wd), 32'(v.wd));
        end
        check({tag, "_ip_update_en"}, 32'(ipu_seen), 32'(v.ipu));
        check({tag, "_value1"}, 32'(v1_act), 32'(v.v1));
        check({tag, "_next_ip"}, 32'(ip), 32'(v.nip));
        check({tag, "_retired"}, 32'(retired), 32'(exp_ret));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t sv;
        int   cyc;
        logic wr;

        for (int i = 0; i < 256; i++) begin
            line_mem[i] = '0; imem[i] = '0; ram_mem[i] = '0;
        end
        imem[8'h01] = 8'h01; imem[8'h02] = 8'h02; imem[8'h03] = 8'h03;
        imem[8'h40] = 8'h40; imem[8'hFF] = 8'hFF;
        ram_mem[1] = 8'd3; ram_mem[2] = 8'd4;

        //             ip     line          br    wr    wa     wd     ipu   nip    v1
        vecs[0] = '{8'h00, 32'h01050102, 1'b0, 1'b1, 8'h05, 8'h07, 1'b0, 8'h01, 8'h03};
        vecs[1] = '{8'h01, 32'h02060501, 1'b0, 1'b1, 8'h06, 8'h04, 1'b0, 8'h02, 8'h07};
        vecs[2] = '{8'h02, 32'h03070605, 1'b0, 1'b1, 8'h07, 8'h03, 1'b0, 8'h03, 8'h04};
        vecs[3] = '{8'h03, 32'h40200102, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h20, 8'h03};
        vecs[4] = '{8'h20, 32'h40300102, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h21, 8'h03};
        vecs[5] = '{8'h21, 32'h01100706, 1'b0, 1'b1, 8'h10, 8'h07, 1'b0, 8'h22, 8'h03};
        vecs[6] = '{8'h22, 32'h40FF0000, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 8'h00};
        vecs[7] = '{8'hFF, 32'h0111050A, 1'b0, 1'b1, 8'h11, 8'h0E, 1'b0, 8'h00, 8'h07};
        vecs[7].line = 32'h01110510;

        rst = 1'b1; start = 1'b0; br = 1'b0; ram_if.ram_busy = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ip", 32'(ip), 32'h0);
        check("reset_retired", 32'(retired), 32'h0);
        check("reset_strobes", 32'({line_mem_en, instr_mem_en, ram_if.ram_rd_en,
                                    ram_if.ram_wr_en, alu_en, ip_update_en, halted}), 32'h0);
        check("reset_regs", 32'({value1, value2, opcode_alu, ram_if.addr_rd}), 32'h0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_fetch", 32'(line_mem_en), 32'h1);

        for (int i = 0; i < 8; i++)
            run_one($sformatf("vec%0d", i), vecs[i], 0, 7, 16'(i + 1));

        // Halt at ip 0, then resume at the same ip.
        line_mem[0] = 32'hFF000000;
        br = 1'b0; cyc = 0; wr = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            if (ram_if.ram_wr_en) wr = 1'b1;
        end while (!halted && cyc < 20);
        check("halt_latency", 32'(cyc), 32'd4);
        check("halt_no_write", 32'(wr), 32'h0);
        check("halt_ip", 32'(ip), 32'h0);
        check("halt_retired", 32'(retired), 32'd8);
        @(negedge clk);
        check("halt_holds", 32'({halted, line_mem_en}), 32'b10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("resume_fetch", 32'({halted, line_mem_en}), 32'b01);
        sv = '{8'h00, 32'h01050102, 1'b0, 1'b1, 8'h05, 8'h07, 1'b0, 8'h01, 8'h03};
        run_one("resume", sv, 0, 7, 16'd9);

        // ram_busy held for three cycles in LOAD1.
        sv = '{8'h01, 32'h01120102, 1'b0, 1'b1, 8'h12, 8'h07, 1'b0, 8'h02, 8'h03};
`ifdef EXEC_CORE_RAM_WAIT_EN
        run_one("stall", sv, 3, 10, 16'd10);
`else
        run_one("stall", sv, 3, 7, 16'd10);
`endif

        // Reset asserted while in WRITE.
        line_mem[ip] = 32'h01130102;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!ram_if.ram_wr_en && cyc < 10);
        check("rstwr_reach_write", 32'(cyc), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        check("rstwr_wr_en", 32'(ram_if.ram_wr_en), 32'h0);
        check("rstwr_outputs", 32'({ip, value1, value2, opcode_alu}), 32'h0);
        check("rstwr_addr_data", 32'({ram_if.addr_rd, ram_if.addr_wr, ram_if.data_wr,
                                      instr_addr}), 32'h0);
        check("rstwr_retired", 32'(retired), 32'h0);
        check("rstwr_strobes", 32'({line_mem_en, instr_mem_en, ram_if.ram_rd_en,
                                    alu_en, ip_update_en, halted}), 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rstwr_idle", 32'({line_mem_en, halted, alu_en}), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
